// File: rtl/ftsd_scan_ctl.sv
// Scan controller for multiplexed 7/14-segment displays.
// Prescaled digit scan with per-frame value latch, digit mask and leading-zero blanking.
//
// Ports:
//   clk, rst     rising-edge clock, synchronous active-high reset
//   en           scan enable; low holds counters and darkens the display
//   din          packed digit values, digit i at din[i*DATA_W +: DATA_W]
//   digit_en     per-digit enable mask (1 = may light)
//   lzb          leading-zero blanking enable
//   ftsd_ctl     active-low digit commons, at most one bit low
//   ftsd_in      value of the selected digit, BLANK_CODE when dark
//   scan_idx     index of the digit slot currently selected
//   frame_start  one-cycle pulse when scan_idx wraps to 0
module ftsd_scan_ctl #(
    parameter int N_DIGITS = 4,
    parameter int DATA_W   = 4,
    parameter int SCAN_DIV = 50000,
    parameter int DIV_W    = 16,
    parameter logic [DATA_W-1:0] BLANK_CODE = {DATA_W{1'b1}}
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic [N_DIGITS*DATA_W-1:0]   din,
    input  logic [N_DIGITS-1:0]          digit_en,
    input  logic                         lzb,
    output logic [N_DIGITS-1:0]          ftsd_ctl,
    output logic [DATA_W-1:0]            ftsd_in,
    output logic [$clog2(N_DIGITS)-1:0]  scan_idx,
    output logic                         frame_start
);

    localparam int IDX_W = $clog2(N_DIGITS);
    localparam logic [DIV_W-1:0] PRESC_MAX = DIV_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_DIGITS - 1);

    logic [DIV_W-1:0]           presc;
    logic [N_DIGITS*DATA_W-1:0] shadow_din;
    logic                       shadow_lzb;

    logic                       tick;
    logic                       wrap;
    logic [IDX_W-1:0]           nxt_idx;
    logic [N_DIGITS*DATA_W-1:0] eff_din;
    logic                       eff_lzb;
    logic                       zsuf;
    logic                       lz;
    logic                       show;
    logic [DATA_W-1:0]          sel_val;
    logic [N_DIGITS-1:0]        ctl_nxt;

    assign tick = en && (presc == PRESC_MAX);
    assign wrap = (scan_idx == IDX_LAST);

    always_comb begin
        nxt_idx = wrap ? '0 : scan_idx + IDX_W'(1);
        // The wrapping tick latches a new frame; digit 0 must
        // already see it, so bypass the shadow on that edge.
        eff_din = wrap ? din : shadow_din;
        eff_lzb = wrap ? lzb : shadow_lzb;
        zsuf    = 1'b1;
        lz      = 1'b0;
        sel_val = BLANK_CODE;
        // Walk from the MS digit down, tracking whether every
        // digit from here upward is zero.
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            if (eff_din[i*DATA_W +: DATA_W] != '0)
                zsuf = 1'b0;
            if (IDX_W'(i) == nxt_idx) begin
                lz      = eff_lzb && (i != 0) && zsuf;
                sel_val = eff_din[i*DATA_W +: DATA_W];
            end
        end
        show = digit_en[nxt_idx] && !lz;
        for (int i = 0; i < N_DIGITS; i++)
            ctl_nxt[i] = !(show && (IDX_W'(i) == nxt_idx));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc       <= '0;
            scan_idx    <= IDX_LAST;
            ftsd_ctl    <= '1;
            ftsd_in     <= BLANK_CODE;
            frame_start <= 1'b0;
            shadow_din  <= '0;
            shadow_lzb  <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            if (!en) begin
                ftsd_ctl <= '1;
                ftsd_in  <= BLANK_CODE;
            end else if (tick) begin
                presc    <= '0;
                scan_idx <= nxt_idx;
                ftsd_ctl <= ctl_nxt;
                ftsd_in  <= show ? sel_val : BLANK_CODE;
                if (wrap) begin
                    shadow_din  <= din;
                    shadow_lzb  <= lzb;
                    frame_start <= 1'b1;
                end
            end else begin
                presc <= presc + DIV_W'(1);
            end
        end
    end

endmodule
